regfile_scoreboard: RTL and testbench

- Parametrised successor to the processor's 2-read/1-write register file.
- Generalised in data width and depth, with a selectable hardwired-zero register 0 and optional write-to-read bypass.
- Adds a per-register busy scoreboard: the issue stage marks a destination register busy when a multicycle op (mult/div) is launched, and writeback clears it.
- Sits between decode and writeback; the stall logic consumes the busy outputs.

---
 rtl/regfile_scoreboard.sv | 172 +++++++++++++++++
 tb/tb_regfile_scoreboard.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_scoreboard.sv
// ---------------------------------------------------------------------------
// regfile_scoreboard
//
// This is a 2-read / 1-write register file with a busy scoreboard for each
// register. The issue stage marks a destination busy when it launches a
// multicycle op (mult/div). Writeback to that register clears the mark. The
// stall logic reads the busy flags through the two read ports and through
// busy_count.
//
// Parameters
//   DATA_WIDTH : width of each register and of the data ports
//   ADDR_WIDTH : register index width; depth = 2**ADDR_WIDTH
//   ZERO_REG   : 1 -> register 0 reads 0, drops writes and issues, is never busy
//   BYPASS     : 1 -> a same-cycle write is forwarded to the matching read port
//                     and masks that port's busy flag
//
// Ports
//   clock            : sole clock; all state updates on the rising edge
//   ctrl_reset       : asynchronous active-high reset (clears data and busy)
//   ctrl_writeEnable : writeback strobe
//   ctrl_writeReg    : writeback destination index
//   data_writeReg    : writeback data
//   ctrl_readRegA/B  : read port indices
//   data_readRegA/B  : read port data (combinational)
//   ctrl_issueEnable : mark ctrl_issueReg busy at the next edge
//   ctrl_issueReg    : register whose result is now pending
//   ctrl_flush       : synchronous clear of every busy bit (data untouched)
//   busy_readRegA/B  : pending-result flag for the register on each read port
//   busy_count       : number of registers currently busy
// ---------------------------------------------------------------------------
module regfile_scoreboard #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter bit ZERO_REG   = 1'b1,
    parameter bit BYPASS     = 1'b1
) (
    input  logic                  clock,
    input  logic                  ctrl_reset,
    input  logic                  ctrl_writeEnable,
    input  logic [ADDR_WIDTH-1:0] ctrl_writeReg,
    input  logic [DATA_WIDTH-1:0] data_writeReg,
    input  logic [ADDR_WIDTH-1:0] ctrl_readRegA,
    input  logic [ADDR_WIDTH-1:0] ctrl_readRegB,
    output logic [DATA_WIDTH-1:0] data_readRegA,
    output logic [DATA_WIDTH-1:0] data_readRegB,
    input  logic                  ctrl_issueEnable,
    input  logic [ADDR_WIDTH-1:0] ctrl_issueReg,
    input  logic                  ctrl_flush,
    output logic                  busy_readRegA,
    output logic                  busy_readRegB,
    output logic [ADDR_WIDTH:0]   busy_count
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    // Register storage and scoreboard, kept as plain flops.
    logic [DATA_WIDTH-1:0] regs_q [DEPTH];
    logic [DATA_WIDTH-1:0] regs_d [DEPTH];
    logic [DEPTH-1:0]      busy_q;
    logic [DEPTH-1:0]      busy_d;

    // -----------------------------------------------------------------------
    // Next state for each register. At the same edge, issue overrides a clear.
    // A clear comes from a flush or from writeback to this register. If an
    // issue and a writeback hit the same register, the data is written and
    // the register stays busy, because a new producer is in flight.
    // -----------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_reg
            localparam logic [ADDR_WIDTH-1:0] IDX = ADDR_WIDTH'(gi);
            localparam bit HARDWIRED = ZERO_REG && (gi == 0);

            logic                  wr_hit;
            logic                  iss_hit;
            logic [DATA_WIDTH-1:0] data_d;
            logic                  busy_bit_d;

            assign wr_hit  = ctrl_writeEnable && (ctrl_writeReg == IDX);
            assign iss_hit = ctrl_issueEnable && (ctrl_issueReg == IDX);

            always_comb begin
                data_d     = regs_q[gi];
                busy_bit_d = busy_q[gi];
                if (wr_hit) begin
                    data_d = data_writeReg;
                end
                if (ctrl_flush || wr_hit) begin
                    busy_bit_d = 1'b0;
                end
                if (iss_hit) begin
                    busy_bit_d = 1'b1;
                end
                // A hardwired zero register stays at 0 and is never busy.
                if (HARDWIRED) begin
                    data_d     = '0;
                    busy_bit_d = 1'b0;
                end
            end

            assign regs_d[gi] = data_d;
            assign busy_d[gi] = busy_bit_d;
        end
    endgenerate

    always_ff @(posedge clock or posedge ctrl_reset) begin
        if (ctrl_reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
            busy_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= regs_d[i];
            end
            busy_q <= busy_d;
        end
    end

    // -----------------------------------------------------------------------
    // Read ports, indexed 0 = A and 1 = B. Bypassing is gated off while reset
    // is held, so outputs read as zero during reset even if a write strobe is
    // active.
    // -----------------------------------------------------------------------
    logic [ADDR_WIDTH-1:0] rd_idx  [2];
    logic [DATA_WIDTH-1:0] rd_data [2];
    logic                  rd_busy [2];

    assign rd_idx[0] = ctrl_readRegA;
    assign rd_idx[1] = ctrl_readRegB;

    generate
        for (gi = 0; gi < 2; gi++) begin : g_rd
            logic [DATA_WIDTH-1:0] data_sel;
            logic                  busy_sel;

            always_comb begin
                data_sel = regs_q[rd_idx[gi]];
                busy_sel = busy_q[rd_idx[gi]];
                if (ZERO_REG && (rd_idx[gi] == '0)) begin
                    data_sel = '0;
                    busy_sel = 1'b0;
                end else if (BYPASS && ctrl_writeEnable && !ctrl_reset &&
                             (ctrl_writeReg == rd_idx[gi])) begin
                    data_sel = data_writeReg;
                    busy_sel = 1'b0;
                end
            end

            assign rd_data[gi] = data_sel;
            assign rd_busy[gi] = busy_sel;
        end
    endgenerate

    assign data_readRegA = rd_data[0];
    assign data_readRegB = rd_data[1];
    assign busy_readRegA = rd_busy[0];
    assign busy_readRegB = rd_busy[1];

    // -----------------------------------------------------------------------
    // busy_count is the combinational popcount of the scoreboard. It cannot
    // drift from the busy bits, and it is valid as soon as they settle after
    // each edge.
    // -----------------------------------------------------------------------
    always_comb begin
        busy_count = '0;
        for (int i = 0; i < DEPTH; i++) begin
            busy_count = busy_count + (ADDR_WIDTH + 1)'(busy_q[i]);
        end
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard. It drives two instances from the same
// inputs: the default build (ZERO_REG=1, BYPASS=1) and a plain build
// (ZERO_REG=0, BYPASS=0). A behavioural model checks both every cycle.
// A hand-computed vector table covers the default build, and a hand-written
// sequence covers the asynchronous reset.
module tb_regfile_scoreboard;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int N  = 32;

    logic          clock = 1'b0;
    logic          ctrl_reset;
    logic          ctrl_writeEnable;
    logic [AW-1:0] ctrl_writeReg;
    logic [DW-1:0] data_writeReg;
    logic [AW-1:0] ctrl_readRegA;
    logic [AW-1:0] ctrl_readRegB;
    logic          ctrl_issueEnable;
    logic [AW-1:0] ctrl_issueReg;
    logic          ctrl_flush;

    logic [DW-1:0] a0, b0, a1, b1;
    logic          ba0, bb0, ba1, bb1;
    logic [AW:0]   c0, c1;

    int tests = 0;
    int fails = 0;

    always #5 clock = ~clock;

    regfile_scoreboard #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut (
        .clock(clock), .ctrl_reset(ctrl_reset),
        .ctrl_writeEnable(ctrl_writeEnable), .ctrl_writeReg(ctrl_writeReg),
        .data_writeReg(data_writeReg),
        .ctrl_readRegA(ctrl_readRegA), .ctrl_readRegB(ctrl_readRegB),
        .data_readRegA(a0), .data_readRegB(b0),
        .ctrl_issueEnable(ctrl_issueEnable), .ctrl_issueReg(ctrl_issueReg),
        .ctrl_flush(ctrl_flush),
        .busy_readRegA(ba0), .busy_readRegB(bb0), .busy_count(c0)
    );

    regfile_scoreboard #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ZERO_REG(1'b0), .BYPASS(1'b0)) dut_plain (
        .clock(clock), .ctrl_reset(ctrl_reset),
        .ctrl_writeEnable(ctrl_writeEnable), .ctrl_writeReg(ctrl_writeReg),
        .data_writeReg(data_writeReg),
        .ctrl_readRegA(ctrl_readRegA), .ctrl_readRegB(ctrl_readRegB),
        .data_readRegA(a1), .data_readRegB(b1),
        .ctrl_issueEnable(ctrl_issueEnable), .ctrl_issueReg(ctrl_issueReg),
        .ctrl_flush(ctrl_flush),
        .busy_readRegA(ba1), .busy_readRegB(bb1), .busy_count(c1)
    );

    // ---------------- comparison ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // cfg 0 = ZERO_REG=1/BYPASS=1, cfg 1 = ZERO_REG=0/BYPASS=0
    logic [DW-1:0] m_data [2][N];
    bit            m_busy [2][N];

    function automatic bit cfg_zero(int cfg);
        return cfg == 0;
    endfunction

    function automatic bit cfg_bypass(int cfg);
        return cfg == 0;
    endfunction

    function automatic logic [DW-1:0] exp_data(int cfg, logic [AW-1:0] idx);
        if (cfg_zero(cfg) && idx == 0) return '0;
        if (cfg_bypass(cfg) && ctrl_writeEnable && !ctrl_reset && ctrl_writeReg == idx)
            return data_writeReg;
        return m_data[cfg][idx];
    endfunction

    function automatic logic exp_busy(int cfg, logic [AW-1:0] idx);
        if (cfg_zero(cfg) && idx == 0) return 1'b0;
        if (cfg_bypass(cfg) && ctrl_writeEnable && !ctrl_reset && ctrl_writeReg == idx)
            return 1'b0;
        return m_busy[cfg][idx];
    endfunction

    function automatic int exp_count(int cfg);
        int s = 0;
        for (int i = 0; i < N; i++) s += int'(m_busy[cfg][i]);
        return s;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < 2; c++)
            for (int i = 0; i < N; i++) begin
                m_data[c][i] = '0;
                m_busy[c][i] = 1'b0;
            end
    endtask

    task automatic model_edge();
        if (ctrl_reset) begin
            model_reset();
            return;
        end
        for (int c = 0; c < 2; c++) begin
            if (ctrl_writeEnable && !(cfg_zero(c) && ctrl_writeReg == 0))
                m_data[c][ctrl_writeReg] = data_writeReg;
            if (ctrl_flush)
                for (int i = 0; i < N; i++) m_busy[c][i] = 1'b0;
            if (ctrl_writeEnable)
                m_busy[c][ctrl_writeReg] = 1'b0;
            if (ctrl_issueEnable && !(cfg_zero(c) && ctrl_issueReg == 0))
                m_busy[c][ctrl_issueReg] = 1'b1;
        end
    endtask

    task automatic model_check();
        chk("m0_data_a", a0, exp_data(0, ctrl_readRegA));
        chk("m0_data_b", b0, exp_data(0, ctrl_readRegB));
        chk("m0_busy_a", ba0, exp_busy(0, ctrl_readRegA));
        chk("m0_busy_b", bb0, exp_busy(0, ctrl_readRegB));
        chk("m0_count", c0, exp_count(0));
        chk("m1_data_a", a1, exp_data(1, ctrl_readRegA));
        chk("m1_data_b", b1, exp_data(1, ctrl_readRegB));
        chk("m1_busy_a", ba1, exp_busy(1, ctrl_readRegA));
        chk("m1_busy_b", bb1, exp_busy(1, ctrl_readRegB));
        chk("m1_count", c1, exp_count(1));
    endtask

    // Inputs change at posedge+1. Checks run at posedge+3, and the model
    // updates at the next posedge.
    task automatic cycle();
        #2;
        model_check();
        @(posedge clock);
        model_edge();
        #1;
    endtask

    task automatic drive(input logic we, input logic [AW-1:0] wr, input logic [DW-1:0] wd,
                         input logic [AW-1:0] ra, input logic [AW-1:0] rb,
                         input logic ie, input logic [AW-1:0] ir, input logic fl);
        ctrl_writeEnable = we;
        ctrl_writeReg    = wr;
        data_writeReg    = wd;
        ctrl_readRegA    = ra;
        ctrl_readRegB    = rb;
        ctrl_issueEnable = ie;
        ctrl_issueReg    = ir;
        ctrl_flush       = fl;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic          we;
        logic [AW-1:0] wr;
        logic [DW-1:0] wd;
        logic [AW-1:0] ra;
        logic [AW-1:0] rb;
        logic          ie;
        logic [AW-1:0] ir;
        logic          fl;
        logic [DW-1:0] ea;
        logic [DW-1:0] eb;
        logic          eba;
        logic          ebb;
        int            ec;
    } vec_t;

    vec_t vt [17];

    initial begin : timeout
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        //        we  wr  wd            ra  rb  ie  ir  fl  ea            eb        eba  ebb  ec
        vt[0]  = '{0,  0,  32'h0,        5,  0,  0,  0,  0,  32'h0,        32'h0,    0,   0,   0};
        vt[1]  = '{1,  5,  32'hDEADBEEF, 5,  0,  0,  0,  0,  32'hDEADBEEF, 32'h0,    0,   0,   0};
        vt[2]  = '{1,  0,  32'h1234,     5,  0,  1,  0,  0,  32'hDEADBEEF, 32'h0,    0,   0,   0};
        vt[3]  = '{0,  0,  32'h0,        0,  0,  0,  0,  0,  32'h0,        32'h0,    0,   0,   0};
        vt[4]  = '{1,  7,  32'hA5A5A5A5, 7,  3,  1,  3,  0,  32'hA5A5A5A5, 32'h0,    0,   0,   0};
        vt[5]  = '{0,  0,  32'h0,        7,  3,  0,  0,  0,  32'hA5A5A5A5, 32'h0,    0,   1,   1};
        vt[6]  = '{1,  3,  32'd42,       3,  3,  0,  0,  0,  32'd42,       32'd42,   0,   0,   1};
        vt[7]  = '{0,  0,  32'h0,        3,  3,  0,  0,  0,  32'd42,       32'd42,   0,   0,   0};
        vt[8]  = '{1,  9,  32'd7,        9,  9,  1,  9,  0,  32'd7,        32'd7,    0,   0,   0};
        vt[9]  = '{0,  0,  32'h0,        9,  9,  0,  0,  0,  32'd7,        32'd7,    1,   1,   1};
        vt[10] = '{0,  0,  32'h0,        1,  2,  1,  1,  0,  32'h0,        32'h0,    0,   0,   1};
        vt[11] = '{0,  0,  32'h0,        1,  2,  1,  2,  0,  32'h0,        32'h0,    1,   0,   2};
        vt[12] = '{0,  0,  32'h0,        2,  4,  1,  4,  0,  32'h0,        32'h0,    1,   0,   3};
        vt[13] = '{0,  0,  32'h0,        4,  6,  1,  6,  1,  32'h0,        32'h0,    1,   0,   4};
        vt[14] = '{0,  0,  32'h0,        6,  9,  0,  0,  0,  32'h0,        32'd7,    1,   0,   1};
        vt[15] = '{1,  6,  32'h55,       6,  1,  0,  0,  1,  32'h55,       32'h0,    0,   0,   1};
        vt[16] = '{0,  0,  32'h0,        6,  6,  0,  0,  0,  32'h55,       32'h55,   0,   0,   0};

        // Reset
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        ctrl_reset = 1'b1;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        ctrl_reset = 1'b0;

        // Table phase (default build checked by hand values, both by model)
        for (int i = 0; i < 17; i++) begin
            drive(vt[i].we, vt[i].wr, vt[i].wd, vt[i].ra, vt[i].rb, vt[i].ie, vt[i].ir, vt[i].fl);
            #1;
            chk($sformatf("vec%0d_data_a", i), a0, vt[i].ea);
            chk($sformatf("vec%0d_data_b", i), b0, vt[i].eb);
            chk($sformatf("vec%0d_busy_a", i), ba0, vt[i].eba);
            chk($sformatf("vec%0d_busy_b", i), bb0, vt[i].ebb);
            chk($sformatf("vec%0d_count", i), c0, vt[i].ec);
            // The plain build has no bypass, so the write in row 1 is not yet visible.
            if (i == 1) chk("plain_no_bypass", a1, 32'h0);
            if (i == 2) chk("plain_after_edge", a1, 32'hDEADBEEF);
            cycle();
        end

        // Asynchronous reset in mid-cycle with r10 busy and written
        drive(1, 10, 32'h77, 10, 10, 1, 10, 0);
        cycle();
        drive(0, 0, 0, 10, 10, 0, 0, 0);
        #2;
        chk("pre_rst_data", a0, 32'h77);
        chk("pre_rst_busy", ba0, 1'b1);
        chk("pre_rst_count", c0, 1);
        #1;
        drive(1, 10, 32'h99, 10, 10, 1, 10, 0);
        ctrl_reset = 1'b1;
        #1;
        chk("async_rst_data_a", a0, 32'h0);
        chk("async_rst_busy_a", ba0, 1'b0);
        chk("async_rst_count", c0, 0);
        chk("async_rst_plain_data", a1, 32'h0);
        chk("async_rst_plain_count", c1, 0);
        @(posedge clock);
        model_edge();
        #1;
        chk("held_rst_data", a0, 32'h0);
        chk("held_rst_count", c0, 0);
        ctrl_reset = 1'b0;
        drive(0, 0, 0, 10, 10, 0, 0, 0);
        #1;
        chk("post_rst_data", a0, 32'h0);
        chk("post_rst_busy", ba0, 1'b0);
        chk("post_rst_plain_busy", ba1, 1'b0);
        cycle();

        // Random phase
        for (int n = 0; n < 400; n++) begin
            logic [AW-1:0] wr;
            wr = AW'($urandom_range(0, N - 1));
            drive(1'($urandom_range(0, 1)), wr, $urandom,
                  ($urandom_range(0, 3) == 0) ? wr : AW'($urandom_range(0, N - 1)),
                  ($urandom_range(0, 3) == 0) ? wr : AW'($urandom_range(0, N - 1)),
                  ($urandom_range(0, 2) == 0),
                  ($urandom_range(0, 4) == 0) ? wr : AW'($urandom_range(0, N - 1)),
                  ($urandom_range(0, 15) == 0));
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
